water_dispenser: RTL and testbench
==================================

Name: water_dispenser

Overview:
- Front-panel controller for a water dispenser.
- The user picks a quantity (0-9) on ten one-hot switches and presses ADD to accumulate it into a running total.
- OK dispenses the total: it counts down one unit per tick until empty. CANCEL clears the total.
- Sits between board switches/push-buttons and a display/valve driver that consume total_amount.

Parameters:
- SWITCH_COUNT, 10: number of selection switches; switch index i selects quantity i.
- MAX_TOTAL, 99: saturation ceiling of the accumulated total.
- TICK_CYCLES, 4: clock cycles per dispensed unit while dispensing.

Ports:
- clock  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- switches  input  SWITCH_COUNT  quantity selection; asynchronous, level.
- button_add  input  1  active-low push-button (idle 1); asynchronous.
- button_ok  input  1  active-low push-button (idle 1); asynchronous.
- button_cancel  input  1  active-low push-button (idle 1); asynchronous.
- total_amount  output  32 (integer)  current total, range 0..MAX_TOTAL.

Behaviour:
- Reset (synchronous, active-high):
  - total_amount=0, state=IDLE, tick counter=0.
  - All button synchronizer/edge flops preset to 1 (released), so no press is generated on reset release.
- Button conditioning (each button):
  - 2-flop synchronizer, then falling-edge detect, giving a one-cycle press pulse per 1->0 transition.
  - Holding a button low produces exactly one pulse.
  - Release generates nothing.
- Press latency: the button is first sampled low at edge k; its effect on total_amount is visible after edge k+2.
- switches: 2-flop synchronized. Selected quantity = index of the highest set switch; 0 if none set.
- States:
  - IDLE (accumulating).
  - DISPENSING.
- IDLE:
  - add press: total <= min(total + quantity, MAX_TOTAL).
  - cancel press: total <= 0.
  - ok press with total > 0: go to DISPENSING, clear tick counter.
  - ok press with total = 0: ignored, stay IDLE.
- DISPENSING:
  - Tick counter counts 0..TICK_CYCLES-1.
  - On each wrap: total <= total - 1.
  - When total reaches 0 on a wrap: return to IDLE.
  - add and ok presses: ignored (dropped, not queued).
  - cancel press: total <= 0, go to IDLE immediately.
- Simultaneous press pulses in the same cycle: priority cancel > ok > add. Only the highest-priority action is taken.
- Saturation: total never exceeds MAX_TOTAL and never goes below 0.
- Reset asserted mid-dispense: returns to reset values on the next edge.
- total_amount is a registered output; no combinational path from inputs.

Decomposition:
- Shared package water_dispenser_pkg holds:
  - SWITCH_COUNT default.
  - state enum {IDLE, DISPENSING}.
  - MAX_TOTAL and TICK_CYCLES defaults.
- One sub-module, button_press_detector:
  - 2-flop synchronizer plus falling-edge detector, reset to released (1).
  - Instantiated three times, once per button.
- Switch synchronizer and priority encoder stay inline.

Test Plan:
- Accumulate then cancel:
  - Add with switch 1, 9, 9, 3, 5 in turn (each press held about 5 cycles) -> total 1, 10, 19, 22, 27.
  - Then cancel -> 0.
- Hold and latency:
  - Hold button_add low for 10 cycles with switch 9 -> total rises by exactly 9.
  - Update appears 3 edges after the first low sample.
- OK with empty total:
  - After cancel, press ok -> remains IDLE, total 0.
  - A following add with switch 3 -> 3.
- Dispense:
  - Total 8 (3+5), press ok -> total decrements 8..0, one unit every 4 cycles (32 cycles total), then IDLE.
  - Add presses (switch 1, then 9) during dispensing are ignored.
- Cancel mid-dispense and priority:
  - Cancel during DISPENSING -> total 0, IDLE next cycle.
  - Add and cancel pressed in the same cycle -> total 0.
- Saturation and reset:
  - Eleven adds with switch 9 -> total 99.
  - Switches 2 and 7 both set -> add 7.
  - Reset asserted mid-dispense -> total 0, IDLE, no spurious press after release.

Source files
------------

// File: rtl/water_dispenser_pkg.sv
// Shared types and default sizing for the water dispenser front panel.
package water_dispenser_pkg;

  localparam int DEF_SWITCH_COUNT = 10;
  localparam int DEF_MAX_TOTAL    = 99;
  localparam int DEF_TICK_CYCLES  = 4;

  typedef enum logic {
    IDLE       = 1'b0,
    DISPENSING = 1'b1
  } state_t;

endpackage

// File: rtl/button_press_detector.sv
// Conditions one active-low push-button: 2-flop synchronizer followed by a
// falling-edge detector. Emits a single-cycle press pulse per 1->0 transition.
module button_press_detector (
  input  logic clock,
  input  logic reset,
  input  logic button,
  output logic press
);

  logic sync1, sync2, prev;

  // Synchronize and keep one cycle of history; reset to released so that
  // leaving reset never looks like a press.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      prev  <= 1'b1;
    end else begin
      sync1 <= button;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign press = prev & ~sync2;

endmodule

// File: rtl/water_dispenser.sv
// Water dispenser controller: accumulates a selected quantity on ADD,
// dispenses one unit per TICK_CYCLES clocks on OK, clears on CANCEL.
module water_dispenser
  import water_dispenser_pkg::*;
#(
  parameter int SWITCH_COUNT = DEF_SWITCH_COUNT,
  parameter int MAX_TOTAL    = DEF_MAX_TOTAL,
  parameter int TICK_CYCLES  = DEF_TICK_CYCLES
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [SWITCH_COUNT-1:0] switches,
  input  logic                    button_add,
  input  logic                    button_ok,
  input  logic                    button_cancel,
  output logic [31:0]             total_amount
);

  localparam int QW  = (SWITCH_COUNT > 1) ? $clog2(SWITCH_COUNT) : 1;
  localparam int TCW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

  logic [SWITCH_COUNT-1:0] sw_meta, sw_sync;
  logic [QW-1:0]           quantity;
  logic [31:0]             sum;
  logic                    add_press, ok_press, cancel_press;
  state_t                  state;
  logic [TCW-1:0]          tick;

  button_press_detector u_add (
    .clock (clock), .reset (reset), .button (button_add),    .press (add_press)
  );
  button_press_detector u_ok (
    .clock (clock), .reset (reset), .button (button_ok),     .press (ok_press)
  );
  button_press_detector u_cancel (
    .clock (clock), .reset (reset), .button (button_cancel), .press (cancel_press)
  );

  // Bring the level switches into the clock domain.
  always_ff @(posedge clock) begin
    if (reset) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= switches;
      sw_sync <= sw_meta;
    end
  end

  // Priority encoder: highest set switch wins, none set selects 0.
  always_comb begin
    quantity = '0;
    for (int i = 0; i < SWITCH_COUNT; i++)
      if (sw_sync[i]) quantity = QW'(i);
  end

  assign sum = total_amount + 32'(quantity);

  // Control FSM with the total kept as a registered output.
  // Press priority is cancel > ok > add; only one action per cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      tick         <= '0;
      total_amount <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cancel_press) begin
            total_amount <= '0;
          end else if (ok_press) begin
            if (total_amount != '0) begin
              state <= DISPENSING;
              tick  <= '0;
            end
          end else if (add_press) begin
            total_amount <= (sum > 32'(MAX_TOTAL)) ? 32'(MAX_TOTAL) : sum;
          end
        end
        DISPENSING: begin
          if (cancel_press) begin
            total_amount <= '0;
            state        <= IDLE;
          end else if (tick == TCW'(TICK_CYCLES - 1)) begin
            tick         <= '0;
            total_amount <= total_amount - 32'd1;
            if (total_amount == 32'd1) state <= IDLE;
          end else begin
            tick <= tick + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_water_dispenser.sv
// Self-checking bench for water_dispenser: directed scenarios plus random
// button/switch/reset traffic, compared every cycle against a reference model.
module tb_water_dispenser;

  localparam int SC   = 10;
  localparam int MAXT = 99;
  localparam int TICK = 4;
  localparam int MAXE = 8192;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [SC-1:0] switches = '0;
  logic          button_add = 1'b1;
  logic          button_ok = 1'b1;
  logic          button_cancel = 1'b1;
  logic [31:0]   total_amount;

  int n_cmp = 0;
  int n_err = 0;

  water_dispenser dut (
    .clock         (clock),
    .reset         (reset),
    .switches      (switches),
    .button_add    (button_add),
    .button_ok     (button_ok),
    .button_cancel (button_cancel),
    .total_amount  (total_amount)
  );

  always #5 clock = ~clock;

  // Input history per rising edge; bit0 add, bit1 ok, bit2 cancel (1 = released).
  logic [2:0]    hb [MAXE];
  logic [SC-1:0] hs [MAXE];
  bit            hr [MAXE];
  int            edge_n = 0;

  // Reference model state.
  int m_total = 0;
  bit m_disp  = 0;
  int m_start = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @edge %0d: got %0d expected %0d", tag, edge_n, got, exp);
    end
  endtask

  function automatic int qty_of(input logic [SC-1:0] s);
    int q = 0;
    for (int i = 0; i < SC; i++) if (s[i]) q = i;
    return q;
  endfunction

  function automatic bit btn_at(input int n, input int b);
    if (n < 0) return 1'b1;
    return hb[n][b];
  endfunction

  // A press acts at edge n when the button was first seen low two edges earlier.
  function automatic bit pressed(input int n, input int b);
    return !btn_at(n - 2, b) && btn_at(n - 3, b);
  endfunction

  task automatic model_edge(input int n);
    bit a, o, c;
    int q;
    if (hr[n]) begin
      m_total = 0;
      m_disp  = 0;
      for (int k = 0; k < 3; k++) if (n - k >= 0) hb[n-k] = 3'b111;
      for (int k = 0; k < 2; k++) if (n - k >= 0) hs[n-k] = '0;
      return;
    end
    a = pressed(n, 0);
    o = pressed(n, 1);
    c = pressed(n, 2);
    q = (n >= 2) ? qty_of(hs[n-2]) : 0;
    if (!m_disp) begin
      if (c) m_total = 0;
      else if (o) begin
        if (m_total > 0) begin
          m_disp  = 1;
          m_start = n;
        end
      end else if (a) m_total = (m_total + q > MAXT) ? MAXT : m_total + q;
    end else begin
      if (c) begin
        m_total = 0;
        m_disp  = 0;
      end else if ((n - m_start) % TICK == 0) begin
        m_total--;
        if (m_total == 0) m_disp = 0;
      end
    end
  endtask

  // One clock: drive inputs, advance the model on the edge, compare mid-cycle.
  task automatic cyc(input bit r, input logic [2:0] btn, input logic [SC-1:0] s);
    reset         = r;
    button_add    = btn[0];
    button_ok     = btn[1];
    button_cancel = btn[2];
    switches      = s;
    hb[edge_n] = btn;
    hs[edge_n] = s;
    hr[edge_n] = r;
    @(posedge clock);
    model_edge(edge_n);
    edge_n++;
    @(negedge clock);
    chk("total", int'(total_amount), m_total);
  endtask

  // Settle switches, hold the masked buttons low, then release.
  task automatic press(input logic [2:0] low, input logic [SC-1:0] s, input int hold);
    for (int i = 0; i < 3; i++) cyc(0, 3'b111, s);
    for (int i = 0; i < hold; i++) cyc(0, ~low, s);
    for (int i = 0; i < 4; i++) cyc(0, 3'b111, s);
  endtask

  function automatic logic [SC-1:0] sw1(input int i);
    logic [SC-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  localparam logic [2:0] ADD = 3'b001, OK = 3'b010, CAN = 3'b100;

  initial begin
    int rem [3];
    bit lvl [3];
    logic [SC-1:0] cur_sw;
    int rst_left;
    int add_seq [5];
    int add_exp [5];
    add_seq = '{1, 9, 9, 3, 5};
    add_exp = '{1, 10, 19, 22, 27};

    @(negedge clock);
    for (int i = 0; i < 3; i++) cyc(1, 3'b111, '0);
    chk("reset", int'(total_amount), 0);
    for (int i = 0; i < 3; i++) cyc(0, 3'b111, '0);
    chk("reset_release", int'(total_amount), 0);

    // Accumulate then cancel.
    for (int i = 0; i < 5; i++) begin
      press(ADD, sw1(add_seq[i]), 5);
      chk("accumulate", int'(total_amount), add_exp[i]);
    end
    press(CAN, '0, 3);
    chk("cancel", int'(total_amount), 0);

    // Hold and latency: first low sample at edge k, update after edge k+2.
    for (int i = 0; i < 3; i++) cyc(0, 3'b111, sw1(9));
    cyc(0, ~ADD, sw1(9)); chk("lat_k",  int'(total_amount), 0);
    cyc(0, ~ADD, sw1(9)); chk("lat_k1", int'(total_amount), 0);
    cyc(0, ~ADD, sw1(9)); chk("lat_k2", int'(total_amount), 9);
    for (int i = 0; i < 7; i++) cyc(0, ~ADD, sw1(9));
    for (int i = 0; i < 4; i++) cyc(0, 3'b111, sw1(9));
    chk("hold_once", int'(total_amount), 9);

    // OK with empty total is ignored.
    press(CAN, '0, 2);
    press(OK, '0, 2);
    chk("ok_empty", int'(total_amount), 0);
    press(ADD, sw1(3), 2);
    chk("add_after_ok", int'(total_amount), 3);

    // Dispense 8 units; adds during dispensing are dropped.
    press(ADD, sw1(5), 2);
    chk("pre_disp", int'(total_amount), 8);
    press(OK, '0, 1);
    press(ADD, sw1(1), 2);
    press(ADD, sw1(9), 2);
    for (int i = 0; i < 12; i++) cyc(0, 3'b111, '0);
    chk("disp_done", int'(total_amount), 0);
    press(ADD, sw1(1), 2);
    chk("idle_after_disp", int'(total_amount), 1);

    // Cancel mid-dispense, then confirm IDLE accepts adds.
    press(ADD, sw1(9), 2);
    press(OK, '0, 1);
    for (int i = 0; i < 6; i++) cyc(0, 3'b111, '0);
    press(CAN, '0, 1);
    chk("cancel_disp", int'(total_amount), 0);
    press(ADD, sw1(2), 2);
    chk("idle_after_cancel", int'(total_amount), 2);

    // Add and cancel in the same cycle: cancel wins.
    press(ADD | CAN, sw1(6), 2);
    chk("prio_cancel", int'(total_amount), 0);

    // Saturation at the ceiling.
    for (int i = 0; i < 11; i++) press(ADD, sw1(9), 2);
    chk("saturate", int'(total_amount), 99);

    // Highest set switch wins.
    press(CAN, '0, 2);
    press(ADD, sw1(2) | sw1(7), 2);
    chk("prio_switch", int'(total_amount), 7);

    // Reset mid-dispense.
    press(OK, '0, 1);
    for (int i = 0; i < 3; i++) cyc(0, 3'b111, '0);
    cyc(1, 3'b111, '0);
    cyc(1, 3'b111, '0);
    chk("rst_mid", int'(total_amount), 0);
    for (int i = 0; i < 10; i++) cyc(0, 3'b111, '0);
    chk("rst_no_spurious", int'(total_amount), 0);

    // Random traffic.
    for (int b = 0; b < 3; b++) begin
      rem[b] = 0;
      lvl[b] = 1'b1;
    end
    cur_sw   = '0;
    rst_left = 0;
    for (int t = 0; t < 3000; t++) begin
      for (int b = 0; b < 3; b++) begin
        if (rem[b] == 0) begin
          lvl[b] = ~lvl[b];
          if (!lvl[b]) rem[b] = $urandom_range(1, 6);
          else rem[b] = (b == 2) ? $urandom_range(10, 60)
                      : (b == 1) ? $urandom_range(5, 30) : $urandom_range(1, 10);
        end
        rem[b]--;
      end
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 3))
          0:       cur_sw = '0;
          1:       cur_sw = SC'($urandom);
          default: cur_sw = sw1($urandom_range(0, SC - 1));
        endcase
      end
      if (rst_left == 0 && $urandom_range(0, 399) == 0) rst_left = $urandom_range(1, 2);
      cyc(rst_left > 0, {lvl[2], lvl[1], lvl[0]}, cur_sw);
      if (rst_left > 0) rst_left--;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
